// File: rtl/kamacore_fetch_unit_if.sv
// Kamacore fetch stage bus bundle.
// Control, imem and decode handshake signals in one place.
interface kamacore_fetch_unit_if #(
  parameter int IW = 32,
  parameter int AW = 16
);
  logic          enable;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;

  modport master (
    input  enable, branch_valid, branch_target,
    input  imem_rdata, out_ready,
    output imem_req, imem_addr,
    output out_valid, out_pc, out_instr
  );

  modport slave (
    output enable, branch_valid, branch_target,
    output imem_rdata, out_ready,
    input  imem_req, imem_addr,
    input  out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/kamacore_fetch_unit.sv
// Kamacore instruction fetch stage.
// PC owner, fixed-latency imem issue, prefetch FIFO to decode.
module kamacore_fetch_unit #(
  parameter int IW = 32,
  parameter int AW = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LATENCY = 1,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  kamacore_fetch_unit_if.master bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MEM_LATENCY + 2);

  if (FIFO_DEPTH < MEM_LATENCY + 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least MEM_LATENCY+1");
  end
  if (MEM_LATENCY < 1) begin : g_bad_lat
    $error("MEM_LATENCY must be at least 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] pc;
  logic [AW-1:0] f_pc [FIFO_DEPTH];
  logic [IW-1:0] f_ins [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] f_cnt;

  logic [MEM_LATENCY-1:0] q_v;
  logic [AW-1:0] q_pc [MEM_LATENCY];
  logic [CW-1:0] q_cnt;

  logic redirect, empty, pop, wb;
  logic credit, issue;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ?
      '0 : p + PW'(1);
  endfunction

  assign redirect = bus.branch_valid;
  assign empty    = (f_cnt == '0);
  assign pop      = bus.out_valid & bus.out_ready;
  assign wb       = q_v[MEM_LATENCY-1] & ~redirect;

  assign bus.out_valid = rst & ~empty & ~redirect;
  assign bus.out_pc    = (rst && !empty) ?
                         f_pc[rd_ptr] : '0;
  assign bus.out_instr = (rst && !empty) ?
                         f_ins[rd_ptr] : '0;
  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc;

  // Count live in-flight fetches for the credit check
  always_comb begin
    q_cnt = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      q_cnt = q_cnt + CW'(q_v[i]);
    end
  end

  assign credit = (f_cnt - CW'(pop) + q_cnt)
                  < CW'(FIFO_DEPTH);

  // Run/idle next state and request decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) state_nxt = RUN;
      end
      RUN: begin
        if (!bus.enable) state_nxt = IDLE;
        issue = rst & credit & ~redirect;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // PC update and in-flight valid pipe
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc  <= RESET_PC;
      q_v <= '0;
    end else begin
      if (redirect)   pc <= bus.branch_target;
      else if (issue) pc <= pc + AW'(1);
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        q_v[i] <= q_v[i-1] & ~redirect;
      end
      q_v[0] <= issue;
    end
  end

  // In-flight PC pipe, paired with returning data
  always_ff @(posedge clk) begin
    for (int i = MEM_LATENCY - 1; i > 0; i--) begin
      q_pc[i] <= q_pc[i-1];
    end
    q_pc[0] <= pc;
  end

  // FIFO pointers and occupancy; redirect flushes
  always_ff @(posedge clk) begin
    if (!rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (wb)  wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      f_cnt <= f_cnt + CW'(wb) - CW'(pop);
    end
  end

  // FIFO storage written on memory return
  always_ff @(posedge clk) begin
    if (rst && wb) begin
      f_pc[wr_ptr]  <= q_pc[MEM_LATENCY-1];
      f_ins[wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_kamacore_fetch_unit.sv
// Testbench for kamacore_fetch_unit.
// Three instances: default, wrapped RESET_PC, latency 3.
module tb_kamacore_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kamacore_fetch_unit_if #(.IW(32), .AW(16)) i0 ();
  kamacore_fetch_unit_if #(.IW(32), .AW(16)) i1 ();
  kamacore_fetch_unit_if #(.IW(32), .AW(16)) i2 ();

  kamacore_fetch_unit #(
    .IW(32), .AW(16), .FIFO_DEPTH(4),
    .MEM_LATENCY(1), .RESET_PC(16'h0000)
  ) d0 (.clk(clk), .rst(rst), .bus(i0));

  kamacore_fetch_unit #(
    .IW(32), .AW(16), .FIFO_DEPTH(4),
    .MEM_LATENCY(1), .RESET_PC(16'hFFFE)
  ) d1 (.clk(clk), .rst(rst), .bus(i1));

  kamacore_fetch_unit #(
    .IW(32), .AW(16), .FIFO_DEPTH(4),
    .MEM_LATENCY(3), .RESET_PC(16'h0000)
  ) d2 (.clk(clk), .rst(rst), .bus(i2));

  function automatic logic [31:0] ins(input logic [15:0] a);
    return {~a, a};
  endfunction

  // instruction memories: word at a is {~a, a}
  logic [15:0] m0, m1, m2a, m2b, m2c;
  always @(posedge clk) begin
    m0  <= i0.imem_addr;
    m1  <= i1.imem_addr;
    m2a <= i2.imem_addr;
    m2b <= m2a;
    m2c <= m2b;
  end
  assign i0.imem_rdata = ins(m0);
  assign i1.imem_rdata = ins(m1);
  assign i2.imem_rdata = ins(m2c);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, en, rdy, bv;
    logic [15:0] tgt;
    logic        req;
    logic [15:0] addr;
    logic        vld, ne;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(
    logic r, logic e, logic y, logic b, logic [15:0] t,
    logic q, logic [15:0] a, logic v, logic n, logic [15:0] p);
    vec_t x;
    x.rst = r; x.en = e; x.rdy = y; x.bv = b; x.tgt = t;
    x.req = q; x.addr = a; x.vld = v; x.ne = n; x.pc = p;
    return x;
  endfunction

  logic [15:0] t4a [6];
  logic [15:0] t4p [6];

  initial begin
    i0.enable = 0; i0.out_ready = 0;
    i0.branch_valid = 0; i0.branch_target = '0;
    i1.enable = 0; i1.out_ready = 0;
    i1.branch_valid = 0; i1.branch_target = '0;
    i2.enable = 0; i2.out_ready = 0;
    i2.branch_valid = 0; i2.branch_target = '0;

    // T1: reset then steady fetch, ready high
    tbl.push_back(row(0,1,1,0,0, 0,0,     0,0,0));
    tbl.push_back(row(0,1,1,0,0, 0,0,     0,0,0));
    tbl.push_back(row(1,1,1,0,0, 0,0,     0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,0,     0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,1,     0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,2,     1,1,0));
    tbl.push_back(row(1,1,1,0,0, 1,3,     1,1,1));
    tbl.push_back(row(1,1,1,0,0, 1,4,     1,1,2));
    // T2: reset, ready low fills FIFO with 4
    tbl.push_back(row(0,1,0,0,0, 0,0,     0,0,0));
    tbl.push_back(row(0,1,0,0,0, 0,0,     0,0,0));
    tbl.push_back(row(1,1,0,0,0, 0,0,     0,0,0));
    tbl.push_back(row(1,1,0,0,0, 1,0,     0,0,0));
    tbl.push_back(row(1,1,0,0,0, 1,1,     0,0,0));
    tbl.push_back(row(1,1,0,0,0, 1,2,     1,1,0));
    tbl.push_back(row(1,1,0,0,0, 1,3,     1,1,0));
    tbl.push_back(row(1,1,0,0,0, 0,0,     1,1,0));
    tbl.push_back(row(1,1,0,0,0, 0,0,     1,1,0));
    tbl.push_back(row(1,1,1,0,0, 1,4,     1,1,0));
    tbl.push_back(row(1,1,1,0,0, 1,5,     1,1,1));
    tbl.push_back(row(1,1,1,0,0, 1,6,     1,1,2));
    tbl.push_back(row(1,1,1,0,0, 1,7,     1,1,3));
    tbl.push_back(row(1,1,1,0,0, 1,8,     1,1,4));
    // T3: redirect with buffered + in-flight work
    tbl.push_back(row(1,1,1,1,16'h40, 0,0, 0,1,5));
    tbl.push_back(row(1,1,1,0,0, 1,16'h40, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h41, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h42, 1,1,16'h40));
    tbl.push_back(row(1,1,1,0,0, 1,16'h43, 1,1,16'h41));
    // back-to-back redirects, last wins
    tbl.push_back(row(1,1,1,1,16'h80, 0,0, 0,1,16'h42));
    tbl.push_back(row(1,1,1,1,16'h90, 0,0, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h90, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h91, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h92, 1,1,16'h90));
    // enable low, redirect while idle, resume
    tbl.push_back(row(1,0,1,0,0, 1,16'h93, 1,1,16'h91));
    tbl.push_back(row(1,0,1,1,16'h20, 0,0, 0,1,16'h92));
    tbl.push_back(row(1,1,1,0,0, 0,0,      0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h20, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h21, 0,0,0));
    tbl.push_back(row(1,1,1,0,0, 1,16'h22, 1,1,16'h20));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst              = tbl[i].rst;
      i0.enable        = tbl[i].en;
      i0.out_ready     = tbl[i].rdy;
      i0.branch_valid  = tbl[i].bv;
      i0.branch_target = tbl[i].tgt;
      #1;
      chk($sformatf("row%0d req", i),
          32'(i0.imem_req), 32'(tbl[i].req));
      if (tbl[i].req)
        chk($sformatf("row%0d addr", i),
            32'(i0.imem_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d valid", i),
          32'(i0.out_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d pc", i),
          32'(i0.out_pc), 32'(tbl[i].pc));
      chk($sformatf("row%0d instr", i), i0.out_instr,
          tbl[i].ne ? ins(tbl[i].pc) : 32'h0);
    end
    i0.branch_valid = 0;

    // T4: PC wrap from 0xFFFE
    t4a = '{16'h0000, 16'hFFFE, 16'hFFFF,
            16'h0000, 16'h0001, 16'h0002};
    t4p = '{16'h0000, 16'h0000, 16'h0000,
            16'hFFFE, 16'hFFFF, 16'h0000};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i0.enable = 0; i0.out_ready = 0;
      i1.enable = 1; i1.out_ready = 1;
      #1;
      chk($sformatf("t4 k%0d req", k),
          32'(i1.imem_req), 32'(k > 0));
      if (k > 0)
        chk($sformatf("t4 k%0d addr", k),
            32'(i1.imem_addr), 32'(t4a[k]));
      chk($sformatf("t4 k%0d valid", k),
          32'(i1.out_valid), 32'(k >= 3));
      if (k >= 3) begin
        chk($sformatf("t4 k%0d pc", k),
            32'(i1.out_pc), 32'(t4p[k]));
        chk($sformatf("t4 k%0d instr", k),
            i1.out_instr, ins(t4p[k]));
      end
    end

    // T5: latency 3, full throughput, then drain
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      i1.enable = 0;
      i2.enable = (k < 10);
      i2.out_ready = 1;
      #1;
      chk($sformatf("t5 k%0d req", k),
          32'(i2.imem_req), 32'(k >= 1 && k <= 10));
      if (k >= 1 && k <= 10)
        chk($sformatf("t5 k%0d addr", k),
            32'(i2.imem_addr), 32'(k - 1));
      chk($sformatf("t5 k%0d valid", k),
          32'(i2.out_valid), 32'(k >= 5 && k <= 14));
      if (k >= 5 && k <= 14) begin
        chk($sformatf("t5 k%0d pc", k),
            32'(i2.out_pc), 32'(k - 5));
        chk($sformatf("t5 k%0d instr", k),
            i2.out_instr, ins(16'(k - 5)));
      end
    end
    i2.enable = 0;

    // T6: fill d0 FIFO, then reset mid-operation
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i0.enable = 1; i0.out_ready = 0;
      #1;
    end
    chk("t6 full req", 32'(i0.imem_req), 32'h0);
    chk("t6 full valid", 32'(i0.out_valid), 32'h1);
    chk("t6 full pc", 32'(i0.out_pc), 32'h21);

    @(negedge clk);
    rst = 0; i0.out_ready = 1;
    #1;
    chk("t6 rst req", 32'(i0.imem_req), 32'h0);
    chk("t6 rst valid", 32'(i0.out_valid), 32'h0);
    chk("t6 rst pc", 32'(i0.out_pc), 32'h0);
    chk("t6 rst instr", i0.out_instr, 32'h0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1;
      #1;
      chk($sformatf("t6 k%0d req", k),
          32'(i0.imem_req), 32'(k >= 1));
      if (k >= 1)
        chk($sformatf("t6 k%0d addr", k),
            32'(i0.imem_addr), 32'(k - 1));
      chk($sformatf("t6 k%0d valid", k),
          32'(i0.out_valid), 32'(k == 3));
      if (k == 3) begin
        chk("t6 first pc", 32'(i0.out_pc), 32'h0);
        chk("t6 first instr", i0.out_instr, ins(16'h0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
